proj_seq_ctrl: RTL and testbench

PROJ_SEQ_CTRL -- requirements
Module: proj_seq_ctrl

---
 rtl/proj_pkg.sv | 42 ++++
 rtl/proj_edge_scan.sv | 118 +++++++++++
 rtl/proj_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_proj_seq_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// -----------------------------------------------------------------------------
// proj_pkg
// Shared definitions for the projection sequencer:
//   - ADDR_W / addr_t : 12-bit pixel-column / RAM address type
//   - state_t         : top-level FSM encoding
//   - scan_result_t   : bundle of the bound computation handed to the top FSM
//   - sat_add/sat_sub : saturating address arithmetic used for the bounds
// -----------------------------------------------------------------------------
package proj_pkg;

    localparam int ADDR_W = 12;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_VS,
        ST_ACCUM,
        ST_SCAN,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic  found;
        addr_t bound_l;
        addr_t bound_r;
    } scan_result_t;

    // min(a + b, max_v), computed one bit wider so the carry cannot wrap.
    function automatic addr_t sat_add(input addr_t a, input addr_t b, input addr_t max_v);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[ADDR_W-1:0];
    endfunction

    // max(a - b, 0)
    function automatic addr_t sat_sub(input addr_t a, input addr_t b);
        return (a >= b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/proj_edge_scan.sv
// -----------------------------------------------------------------------------
// proj_edge_scan
// Walks the projection RAM from address 0 to IMG_WIDTH_LINE-1 while scan_en is
// high, finds the first rising edge and the first falling edge after it, and
// turns them into left/right object bounds.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   scan_en     : high for the whole SCAN state; low clears all scan state
//   ram_raddr   : read address to the external RAM (1-cycle read latency)
//   ram_dout    : read data, belongs to the address issued one cycle earlier
//   done        : high in the cycle the last datum is consumed
//   result      : bounds and found flag, valid while done is high
// -----------------------------------------------------------------------------
module proj_edge_scan
    import proj_pkg::*;
#(
    parameter int IMG_WIDTH_LINE = 1920,
    parameter int OFFSET_L       = 16,
    parameter int OFFSET_R       = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic              ram_dout,
    output logic              done,
    output scan_result_t      result
);

    localparam addr_t LAST    = addr_t'(IMG_WIDTH_LINE - 1);
    localparam addr_t CNT_END = addr_t'(IMG_WIDTH_LINE);
    localparam addr_t OFS_L   = addr_t'(OFFSET_L);
    localparam addr_t OFS_R   = addr_t'(OFFSET_R);
    localparam addr_t ONE     = addr_t'(1);

    // cnt_q counts scan cycles 0..IMG_WIDTH_LINE; data for address cnt_q-1
    // arrives in cycle cnt_q, so the scan spans IMG_WIDTH_LINE+1 cycles.
    addr_t cnt_q, cnt_d;
    logic  prev_q, prev_d;
    logic  rise_q, rise_d;
    logic  fall_q, fall_d;
    addr_t l_q, l_d;
    addr_t r_q, r_d;

    logic  data_vld;
    logic  last_dat;
    logic  rise_now;
    addr_t dat_addr;

    assign ram_raddr = (cnt_q > LAST) ? LAST : cnt_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        l_d      = l_q;
        r_d      = r_q;
        dat_addr = cnt_q - ONE;
        data_vld = scan_en && (cnt_q != '0);
        last_dat = scan_en && (cnt_q == CNT_END);
        rise_now = data_vld && !rise_q && ram_dout && !prev_q;

        if (!scan_en) begin
            // Outside SCAN everything rests at zero, which also forces the
            // "previous bit" to 0 for the first datum of the next scan.
            cnt_d  = '0;
            prev_d = 1'b0;
            rise_d = 1'b0;
            fall_d = 1'b0;
            l_d    = '0;
            r_d    = '0;
        end else begin
            cnt_d = cnt_q + ONE;
            if (data_vld) begin
                prev_d = ram_dout;
                if (rise_now) begin
                    rise_d = 1'b1;
                    l_d    = sat_add(dat_addr, OFS_L, LAST);
                end else if (rise_q && !fall_q && prev_q && !ram_dout) begin
                    fall_d = 1'b1;
                    r_d    = sat_sub(dat_addr, OFS_R);
                end
                // A run that never falls is closed at the last column.
                if (last_dat && (rise_q || rise_now) && !fall_q && ram_dout) begin
                    r_d = sat_sub(LAST, OFS_R);
                end
            end
        end

        done           = last_dat;
        result.found   = rise_d && (r_d >= l_d);
        result.bound_l = l_d;
        result.bound_r = r_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            l_q    <= '0;
            r_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            l_q    <= l_d;
            r_q    <= r_d;
        end
    end

endmodule

// File: rtl/proj_seq_ctrl.sv
// -----------------------------------------------------------------------------
// proj_seq_ctrl
// Column-projection sequencer. Each cycle: clear the external projection RAM,
// wait for a frame start, accumulate marked pixel columns for one frame, scan
// the RAM for the object's horizontal extent, and report it with a
// valid/ack handshake. Repeats while i_enable is high.
//
// Ports:
//   pixelclk, reset_n            : clock, asynchronous active-low reset
//   i_enable                     : run continuous cycles
//   i_vs, i_de, i_hcount, i_mark : video timing and per-pixel object mark
//   ram_we/ram_waddr/ram_din     : RAM write port
//   ram_raddr/ram_dout           : RAM read port (1-cycle read latency)
//   o_valid/i_ack                : result handshake
//   o_found, o_bound_l, o_bound_r: result, stable while o_valid is high
//   o_busy                       : high in every state except IDLE
// -----------------------------------------------------------------------------
module proj_seq_ctrl
    import proj_pkg::*;
#(
    parameter int IMG_WIDTH_LINE = 1920,
    parameter int OFFSET_L       = 16,
    parameter int OFFSET_R       = 22
) (
    input  logic              pixelclk,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic              i_vs,
    input  logic              i_de,
    input  logic [ADDR_W-1:0] i_hcount,
    input  logic              i_mark,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_din,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic              ram_dout,
    output logic              o_valid,
    input  logic              i_ack,
    output logic              o_found,
    output logic [ADDR_W-1:0] o_bound_l,
    output logic [ADDR_W-1:0] o_bound_r,
    output logic              o_busy
);

    localparam addr_t LAST = addr_t'(IMG_WIDTH_LINE - 1);
    localparam addr_t ONE  = addr_t'(1);

    state_t state_q, state_d;
    addr_t  clr_cnt_q, clr_cnt_d;
    logic   vs_q;
    logic   valid_q, valid_d;
    logic   found_q, found_d;
    addr_t  bound_l_q, bound_l_d;
    addr_t  bound_r_q, bound_r_d;
    logic   busy_q, busy_d;

    logic         vs_fall;
    logic         accum_wr;
    logic         scan_en;
    logic         scan_done;
    scan_result_t scan_res;

    assign vs_fall  = vs_q && !i_vs;
    assign accum_wr = (state_q == ST_ACCUM) && i_de && i_mark && (i_hcount <= LAST);
    assign scan_en  = (state_q == ST_SCAN);

    proj_edge_scan #(
        .IMG_WIDTH_LINE (IMG_WIDTH_LINE),
        .OFFSET_L       (OFFSET_L),
        .OFFSET_R       (OFFSET_R)
    ) u_edge_scan (
        .clk       (pixelclk),
        .rst_n     (reset_n),
        .scan_en   (scan_en),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout),
        .done      (scan_done),
        .result    (scan_res)
    );

    // The write port is decoded from the current state and inputs rather than
    // registered: the pixel that coincides with the closing vs edge must still
    // land in the RAM, and writes must stop exactly when CLEAR/ACCUM end.
    // The RAM itself is never reset; CLEAR always runs before ACCUM.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_din   = 1'b0;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
        end else if (accum_wr) begin
            ram_we    = 1'b1;
            ram_waddr = i_hcount;
            ram_din   = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        valid_d   = valid_q;
        found_d   = found_q;
        bound_l_d = bound_l_q;
        bound_r_d = bound_r_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d   = ST_WAIT_VS;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ONE;
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (vs_fall) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_done) begin
                    state_d   = ST_REPORT;
                    valid_d   = 1'b1;
                    found_d   = scan_res.found;
                    bound_l_d = scan_res.bound_l;
                    bound_r_d = scan_res.bound_r;
                end
            end
            ST_REPORT: begin
                // Results are left in place after the handshake; only valid drops.
                if (valid_q && i_ack) begin
                    valid_d   = 1'b0;
                    clr_cnt_d = '0;
                    state_d   = i_enable ? ST_CLEAR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            vs_q      <= 1'b0;
            valid_q   <= 1'b0;
            found_q   <= 1'b0;
            bound_l_q <= '0;
            bound_r_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            vs_q      <= i_vs;
            valid_q   <= valid_d;
            found_q   <= found_d;
            bound_l_q <= bound_l_d;
            bound_r_q <= bound_r_d;
            busy_q    <= busy_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_found   = found_q;
    assign o_bound_l = bound_l_q;
    assign o_bound_r = bound_r_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_proj_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_proj_seq_ctrl
// Drives frames of marked columns into proj_seq_ctrl with a behavioural RAM.
// The frame driver pushes the expected result (computed from the column set)
// into a queue; an independent monitor pops and compares when o_valid rises,
// checks that results hold until ack, and then acknowledges.
// -----------------------------------------------------------------------------
module tb_proj_seq_ctrl;

    localparam int IMG   = 1920;
    localparam int OFS_L = 16;
    localparam int OFS_R = 22;

    logic        pixelclk;
    logic        reset_n;
    logic        i_enable;
    logic        i_vs;
    logic        i_de;
    logic [11:0] i_hcount;
    logic        i_mark;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic        ram_din;
    logic [11:0] ram_raddr;
    logic        ram_dout;
    logic        o_valid;
    logic        i_ack;
    logic        o_found;
    logic [11:0] o_bound_l;
    logic [11:0] o_bound_r;
    logic        o_busy;

    proj_seq_ctrl #(
        .IMG_WIDTH_LINE (IMG),
        .OFFSET_L       (OFS_L),
        .OFFSET_R       (OFS_R)
    ) dut (
        .pixelclk  (pixelclk),
        .reset_n   (reset_n),
        .i_enable  (i_enable),
        .i_vs      (i_vs),
        .i_de      (i_de),
        .i_hcount  (i_hcount),
        .i_mark    (i_mark),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout),
        .o_valid   (o_valid),
        .i_ack     (i_ack),
        .o_found   (o_found),
        .o_bound_l (o_bound_l),
        .o_bound_r (o_bound_r),
        .o_busy    (o_busy)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    // ---------------- external RAM model (power-up content all ones) -------
    logic mem [0:IMG-1];
    initial for (int i = 0; i < IMG; i++) mem[i] = 1'b1;

    always @(posedge pixelclk) begin
        if (ram_we && int'(ram_waddr) < IMG) mem[ram_waddr] <= ram_din;
        ram_dout <= (int'(ram_raddr) < IMG) ? mem[ram_raddr] : 1'b0;
    end

    // ---------------- bookkeeping ------------------------------------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit found;
        int l;
        int r;
    } exp_t;

    exp_t sb_q[$];
    int   frames_sent = 0;
    int   acks_done   = 0;

    // Reference: bounds from the set of marked columns, straight from the rules.
    function automatic exp_t model(input bit [IMG-1:0] bm);
        exp_t e;
        int   first;
        int   stop;
        e     = '{found: 1'b0, l: 0, r: 0};
        first = -1;
        stop  = -1;
        for (int i = 0; i < IMG; i++) begin
            if (bm[i]) begin
                first = i;
                break;
            end
        end
        if (first < 0) return e;
        for (int j = first + 1; j < IMG; j++) begin
            if (!bm[j]) begin
                stop = j;
                break;
            end
        end
        e.l = (first + OFS_L > IMG - 1) ? IMG - 1 : first + OFS_L;
        e.r = (stop < 0) ? (IMG - 1 - OFS_R) : (stop - OFS_R);
        if (e.r < 0) e.r = 0;
        e.found = (e.r >= e.l);
        return e;
    endfunction

    function automatic bit [IMG-1:0] set_run(input bit [IMG-1:0] bm, input int lo, input int hi);
        bit [IMG-1:0] b;
        b = bm;
        for (int i = lo; i <= hi; i++) b[i] = 1'b1;
        return b;
    endfunction

    // Counts CLEAR writes (din=0) and verifies they walk 0..IMG-1 in order.
    int clr_total     = 0;
    bit clr_order_bad = 1'b0;

    always @(negedge pixelclk) begin
        if (reset_n && ram_we && !ram_din) begin
            if (int'(ram_waddr) != (clr_total % IMG)) clr_order_bad <= 1'b1;
            clr_total <= clr_total + 1;
        end
    end

    // ---------------- monitor / scoreboard checker -------------------------
    initial begin
        exp_t        e;
        logic        cap_f;
        logic [11:0] cap_l;
        logic [11:0] cap_r;
        int          hold;
        i_ack = 1'b0;
        forever begin
            @(negedge pixelclk);
            i_ack = 1'b0;
            if (reset_n && o_valid) begin
                check("sb_has_entry", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("found", int'(o_found), int'(e.found));
                    check("bound_l", int'(o_bound_l), e.l);
                    check("bound_r", int'(o_bound_r), e.r);
                end
                cap_f = o_found;
                cap_l = o_bound_l;
                cap_r = o_bound_r;
                hold  = $urandom_range(0, 4);
                repeat (hold) begin
                    @(negedge pixelclk);
                    check("valid_held", int'(o_valid), 1);
                    check("found_stable", int'(o_found), int'(cap_f));
                    check("bound_l_stable", int'(o_bound_l), int'(cap_l));
                    check("bound_r_stable", int'(o_bound_r), int'(cap_r));
                end
                i_ack = 1'b1;
                @(negedge pixelclk);
                i_ack = 1'b0;
                check("valid_drop_after_ack", int'(o_valid), 0);
                acks_done++;
            end else if ($urandom_range(0, 40) == 0) begin
                i_ack = 1'b1;  // stray ack with no result pending
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    int clr_snap = 0;

    task automatic cycles(input int n);
        repeat (n) @(negedge pixelclk);
    endtask

    task automatic wait_acked();
        int budget;
        budget = 0;
        while (acks_done != frames_sent && budget < 8000) begin
            @(negedge pixelclk);
            budget++;
        end
        check("result_ack_timeout", acks_done, frames_sent);
    endtask

    task automatic pixel(input int col);
        i_de     = 1'b1;
        i_mark   = 1'b1;
        i_hcount = 12'(col);
        @(negedge pixelclk);
        i_de   = 1'b0;
        i_mark = 1'b0;
    endtask

    // One cycle of input that must not reach the RAM.
    task automatic noise();
        case ($urandom_range(0, 2))
            0: begin i_de = 1'b0; i_mark = 1'b1; i_hcount = 12'($urandom_range(0, IMG - 1)); end
            1: begin i_de = 1'b1; i_mark = 1'b0; i_hcount = 12'($urandom_range(0, IMG - 1)); end
            default: begin i_de = 1'b1; i_mark = 1'b1; i_hcount = 12'($urandom_range(IMG, 4095)); end
        endcase
        @(negedge pixelclk);
        i_de   = 1'b0;
        i_mark = 1'b0;
    endtask

    // Assumes CLEAR has finished; checks it and opens the frame.
    task automatic start_frame();
        check("busy_before_frame", int'(o_busy), 1);
        check("clear_write_count", clr_total - clr_snap, IMG);
        check("clear_write_order", int'(clr_order_bad), 0);
        clr_snap = clr_total;
        i_vs = 1'b1;
        @(negedge pixelclk);
        i_vs = 1'b0;
        @(negedge pixelclk);
    endtask

    task automatic run_frame(input bit [IMG-1:0] bm, input bit drop_en);
        int last;
        bit use_fall;
        wait_acked();
        cycles(IMG + 8);
        start_frame();
        if (drop_en) i_enable = 1'b0;
        last = -1;
        for (int c = 0; c < IMG; c++) if (bm[c]) last = c;
        use_fall = (last >= 0) && ($urandom_range(0, 1) == 1);
        for (int c = 0; c < IMG; c++) begin
            if (bm[c] && !(use_fall && c == last)) begin
                if ($urandom_range(0, 5) == 0) noise();
                pixel(c);
            end
        end
        noise();
        i_vs = 1'b1;
        @(negedge pixelclk);
        i_vs = 1'b0;
        if (use_fall) pixel(last);   // lands in the cycle that closes the frame
        else @(negedge pixelclk);
        sb_q.push_back(model(bm));
        frames_sent++;
    endtask

    bit [IMG-1:0] bm;
    int           lo;
    int           hi;
    int           snap_end;

    initial begin
        reset_n  = 1'b0;
        i_enable = 1'b0;
        i_vs     = 1'b0;
        i_de     = 1'b0;
        i_hcount = '0;
        i_mark   = 1'b0;
        cycles(3);
        check("rst_valid", int'(o_valid), 0);
        check("rst_found", int'(o_found), 0);
        check("rst_bound_l", int'(o_bound_l), 0);
        check("rst_bound_r", int'(o_bound_r), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_waddr", int'(ram_waddr), 0);
        check("rst_ram_raddr", int'(ram_raddr), 0);
        reset_n = 1'b1;
        cycles(4);
        check("idle_without_enable", int'(o_busy), 0);
        check("no_write_in_idle", int'(ram_we), 0);

        i_enable = 1'b1;

        // Directed frames.
        bm = '0; bm = set_run(bm, 100, 499);            run_frame(bm, 1'b0);
        bm = '0;                                        run_frame(bm, 1'b0);
        bm = '0; bm = set_run(bm, 1900, 1919);          run_frame(bm, 1'b0);
        bm = '0; bm = set_run(bm, 0, 10);               run_frame(bm, 1'b0);
        bm = '0; bm = set_run(bm, 50, 60);
                 bm = set_run(bm, 300, 400);            run_frame(bm, 1'b0);

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            bm = '0;
            for (int k = 0, n = $urandom_range(0, 3); k < n; k++) begin
                lo = $urandom_range(0, IMG - 1);
                hi = lo + $urandom_range(0, 120);
                if (f == 2 && k == 0) lo = 0;
                if (f == 3 && k == 0) hi = IMG - 1;
                if (hi > IMG - 1) hi = IMG - 1;
                bm = set_run(bm, lo, hi);
            end
            run_frame(bm, 1'b0);
        end

        // Reset in the middle of ACCUM abandons the frame.
        wait_acked();
        cycles(IMG + 8);
        start_frame();
        for (int c = 10; c <= 30; c++) pixel(c);
        i_de     = 1'b1;
        i_mark   = 1'b1;
        i_hcount = 12'd40;
        reset_n  = 1'b0;
        @(negedge pixelclk);
        check("midreset_valid", int'(o_valid), 0);
        check("midreset_busy", int'(o_busy), 0);
        check("midreset_ram_we", int'(ram_we), 0);
        i_de   = 1'b0;
        i_mark = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        check("restart_after_reset", int'(o_busy), 1);
        bm = '0; bm = set_run(bm, 700, 800);            run_frame(bm, 1'b0);

        // Enable dropped mid-frame: cycle completes, then the block idles.
        bm = '0; bm = set_run(bm, 1200, 1500);          run_frame(bm, 1'b1);
        wait_acked();
        snap_end = clr_total;
        cycles(20);
        check("idle_after_disable", int'(o_busy), 0);
        check("no_clear_after_disable", clr_total - snap_end, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog");
    end

endmodule
